camera_follow: RTL

//   Downstream consumer of center_of_mass. Latches the car's latest centre of mass and,

---
 rtl/camera_pkg.sv | 15 +
 rtl/camera_axis.sv | 81 ++++++++
 rtl/camera_follow.sv | 120 ++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared camera-follow types: FSM state encoding and axis indices (also used by the renderer).
package camera_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        STEP,
        CLAMP,
        OUT
    } cam_state_t;

    localparam int unsigned AXIS_X = 0;
    localparam int unsigned AXIS_Y = 1;

endpackage

// File: rtl/camera_axis.sv
// One camera axis: error, deadzone, shift-smoothed step and clamp.
// Registered stages advance only on the enables supplied by the top-level FSM.
module camera_axis
    import camera_pkg::*;
#(
    parameter int unsigned POSITION_SIZE = 12,
    parameter int          HALF          = 640,
    parameter int          DZ            = 64,
    parameter int unsigned SHIFT         = 2,
    parameter int          CAM_MIN       = 0,
    parameter int          CAM_MAX       = 1024
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            err_en,
    input  logic                            step_en,
    input  logic                            have_target,
    input  logic signed [POSITION_SIZE-1:0] snap,
    input  logic signed [POSITION_SIZE-1:0] cam,
    output logic signed [POSITION_SIZE-1:0] nxt_c
);

    // Two guard bits cover snap - HALF - cam and cam + step without overflow.
    localparam int unsigned EW = POSITION_SIZE + 2;

    logic signed [EW-1:0] err_q;
    logic signed [EW-1:0] step_q;
    logic signed [EW-1:0] err_c;
    logic signed [EW-1:0] mag_c;
    logic signed [EW-1:0] over_c;
    logic signed [EW-1:0] shifted_c;
    logic signed [EW-1:0] step_c;
    logic signed [EW-1:0] sum_c;

    always_comb begin
        err_c = '0;
        if (have_target) begin
            err_c = EW'(snap) - EW'(HALF) - EW'(cam);
        end
    end

    // Shift the magnitude, not the signed error, so rounding is toward zero.
    always_comb begin
        mag_c     = err_q[EW-1] ? -err_q : err_q;
        over_c    = mag_c - EW'(DZ);
        shifted_c = over_c >>> SHIFT;
        step_c    = '0;
        if (mag_c > EW'(DZ)) begin
            step_c = (shifted_c == '0) ? EW'(1) : shifted_c;
            if (err_q[EW-1]) begin
                step_c = -step_c;
            end
        end
    end

    always_comb begin
        sum_c = EW'(cam) + step_q;
        if (sum_c < EW'(CAM_MIN)) begin
            nxt_c = POSITION_SIZE'(CAM_MIN);
        end else if (sum_c > EW'(CAM_MAX)) begin
            nxt_c = POSITION_SIZE'(CAM_MAX);
        end else begin
            nxt_c = POSITION_SIZE'(sum_c);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_q  <= '0;
            step_q <= '0;
        end else begin
            if (err_en) begin
                err_q <= err_c;
            end
            if (step_en) begin
                step_q <= step_c;
            end
        end
    end

endmodule

// File: rtl/camera_follow.sv
// Camera follow: latches the latest centre of mass and, once per frame,
// steps the 2-axis camera offset toward it through the per-axis datapath.
module camera_follow
    import camera_pkg::*;
#(
    parameter int unsigned POSITION_SIZE = 12,
    parameter int          HALF_W        = 640,
    parameter int          HALF_H        = 360,
    parameter int          DZ_X          = 64,
    parameter int          DZ_Y          = 48,
    parameter int unsigned SHIFT         = 2,
    parameter int          CAM_X_MIN     = 0,
    parameter int          CAM_X_MAX     = 1024,
    parameter int          CAM_Y_MIN     = 0,
    parameter int          CAM_Y_MAX     = 512
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic signed [POSITION_SIZE-1:0] com_in [1:0],
    input  logic                            com_valid_in,
    input  logic                            new_frame_in,
    output logic signed [POSITION_SIZE-1:0] cam_out [1:0],
    output logic                            cam_valid_out,
    output logic                            frame_overrun_out
);

    cam_state_t                      state;
    logic signed [POSITION_SIZE-1:0] target [1:0];
    logic signed [POSITION_SIZE-1:0] snap   [1:0];
    logic                            have_target;
    logic                            snap_have;
    logic signed [POSITION_SIZE-1:0] nxt_x_c;
    logic signed [POSITION_SIZE-1:0] nxt_y_c;

    camera_axis #(
        .POSITION_SIZE(POSITION_SIZE),
        .HALF         (HALF_W),
        .DZ           (DZ_X),
        .SHIFT        (SHIFT),
        .CAM_MIN      (CAM_X_MIN),
        .CAM_MAX      (CAM_X_MAX)
    ) u_axis_x (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .err_en     (state == ERR),
        .step_en    (state == STEP),
        .have_target(snap_have),
        .snap       (snap[AXIS_X]),
        .cam        (cam_out[AXIS_X]),
        .nxt_c      (nxt_x_c)
    );

    camera_axis #(
        .POSITION_SIZE(POSITION_SIZE),
        .HALF         (HALF_H),
        .DZ           (DZ_Y),
        .SHIFT        (SHIFT),
        .CAM_MIN      (CAM_Y_MIN),
        .CAM_MAX      (CAM_Y_MAX)
    ) u_axis_y (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .err_en     (state == ERR),
        .step_en    (state == STEP),
        .have_target(snap_have),
        .snap       (snap[AXIS_Y]),
        .cam        (cam_out[AXIS_Y]),
        .nxt_c      (nxt_y_c)
    );

    // Target latch runs every cycle; the FSM only ever reads the frame-start snapshot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= IDLE;
            target[AXIS_X]    <= '0;
            target[AXIS_Y]    <= '0;
            snap[AXIS_X]      <= '0;
            snap[AXIS_Y]      <= '0;
            have_target       <= 1'b0;
            snap_have         <= 1'b0;
            cam_out[AXIS_X]   <= POSITION_SIZE'(CAM_X_MIN);
            cam_out[AXIS_Y]   <= POSITION_SIZE'(CAM_Y_MIN);
            cam_valid_out     <= 1'b0;
            frame_overrun_out <= 1'b0;
        end else begin
            cam_valid_out <= 1'b0;
            if (com_valid_in) begin
                target[AXIS_X] <= com_in[AXIS_X];
                target[AXIS_Y] <= com_in[AXIS_Y];
                have_target    <= 1'b1;
            end
            if (new_frame_in && (state != IDLE)) begin
                frame_overrun_out <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (new_frame_in) begin
                        snap[AXIS_X] <= target[AXIS_X];
                        snap[AXIS_Y] <= target[AXIS_Y];
                        snap_have    <= have_target;
                        state        <= ERR;
                    end
                end
                ERR:   state <= STEP;
                STEP:  state <= CLAMP;
                CLAMP: begin
                    cam_out[AXIS_X] <= nxt_x_c;
                    cam_out[AXIS_Y] <= nxt_y_c;
                    state           <= OUT;
                end
                OUT: begin
                    cam_valid_out <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
